// File: rtl/mmio_uart_pkg.sv
// mmio_uart_pkg: register offsets, STATUS bit positions and transmit FSM states for mmio_uart_tx.
// MMIO_UART_TX_PARITY_EN adds the PARITY state.
package mmio_uart_pkg;
    localparam logic [1:0] TXDATA = 2'd0;
    localparam logic [1:0] STATUS = 2'd1;
    localparam logic [1:0] BAUD   = 2'd2;
    localparam logic [1:0] CTRL   = 2'd3;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_CNT   = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef MMIO_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } uart_tx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO; head entry is visible combinationally on data_o.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0] cnt_q;
    logic do_push, do_pop;

    always_comb begin
        full_o = cnt_q == FULL_CNT;
        empty_o = cnt_q == '0;
        count_o = cnt_q;
        data_o = mem_q[rp_q];
        do_pop = pop_i && !empty_o;
        // a full FIFO still accepts a push when the head leaves on the same edge
        do_push = push_i && (!full_o || do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
            cnt_q <= '0;
        end else begin
            wp_q <= wp_q + AW'(do_push);
            rp_q <= rp_q + AW'(do_pop);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wp_q] <= data_i;
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter with TX FIFO, 8N1 framing on uart_tx.
// Define MMIO_UART_TX_PARITY_EN to add CTRL.parity_odd and a parity bit before STOP.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR        = 32'h0000_4000,
    parameter int          FIFO_DEPTH       = 8,
    parameter logic [15:0] DEFAULT_BAUD_DIV = 16'd533
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] core_addr,
    input  logic        core_wr_ena,
    input  logic [31:0] core_wr_data,
    output logic [31:0] core_rd_data,
    output logic        hit,
    output logic        uart_tx
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    uart_tx_state_t state_q, state_d;
    logic [15:0] baud_q, baud_d, tmr_q, tmr_d;
    logic [7:0] shift_q, shift_d, head;
    logic [2:0] idx_q, idx_d;
    logic ovf_q, ovf_d, en_q, en_d, tx_q, tx_d, hit_q;
    logic [31:0] rd_q, rd_d, status, ctrl;
    logic [CW-1:0] count;
    logic [8:0] cnt9;
    logic [1:0] ra;
    logic sel, wr, push, pop, full, empty, bit_end, unused_bits;
`ifdef MMIO_UART_TX_PARITY_EN
    logic odd_q, odd_d, par_q, par_d;
`endif

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (core_wr_data[7:0]),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_comb begin
        sel = core_addr[31:4] == BASE_ADDR[31:4];
        wr = sel && core_wr_ena;
        ra = core_addr[3:2];
        push = wr && ra == TXDATA;
        bit_end = tmr_q == 16'd0;
        // STOP hands straight to START when another byte is waiting, so frames abut
        pop = !empty && en_q && (state_q == IDLE || (state_q == STOP && bit_end));
        ovf_d = (push && full && !pop) ? 1'b1 : (wr && ra == STATUS && core_wr_data[3]) ? 1'b0 : ovf_q;
        baud_d = (wr && ra == BAUD) ? (core_wr_data[15:0] < 16'd2 ? 16'd2 : core_wr_data[15:0]) : baud_q;
        en_d = (wr && ra == CTRL) ? core_wr_data[0] : en_q;
        tmr_d = (state_q == IDLE || bit_end) ? baud_q - 16'd1 : tmr_q - 16'd1;
        state_d = state_q;
        shift_d = shift_q;
        idx_d = idx_q;
`ifdef MMIO_UART_TX_PARITY_EN
        odd_d = (wr && ra == CTRL) ? core_wr_data[1] : odd_q;
        par_d = par_q;
`endif
        case (state_q)
            START: state_d = bit_end ? DATA : START;
            DATA: if (bit_end) begin
                shift_d = shift_q >> 1;
                idx_d = idx_q + 3'd1;
`ifdef MMIO_UART_TX_PARITY_EN
                state_d = idx_q == 3'd7 ? PARITY : DATA;
`else
                state_d = idx_q == 3'd7 ? STOP : DATA;
`endif
            end
`ifdef MMIO_UART_TX_PARITY_EN
            PARITY: state_d = bit_end ? STOP : PARITY;
`endif
            STOP: state_d = bit_end ? IDLE : STOP;
            default: state_d = state_q;
        endcase
        if (pop) begin
            state_d = START;
            shift_d = head;
            idx_d = 3'd0;
`ifdef MMIO_UART_TX_PARITY_EN
            par_d = ^head ^ odd_q;
`endif
        end
`ifdef MMIO_UART_TX_PARITY_EN
        tx_d = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : state_q == PARITY ? par_q : 1'b1;
        ctrl = {30'd0, odd_q, en_q};
`else
        tx_d = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
        ctrl = {31'd0, en_q};
`endif
        cnt9 = 9'(count);
        status = '0;
        status[ST_FULL] = full;
        status[ST_EMPTY] = empty;
        status[ST_BUSY] = state_q != IDLE;
        status[ST_OVF] = ovf_q;
        status[ST_CNT +: 8] = cnt9[7:0];
        rd_d = !sel ? 32'd0 : ra == STATUS ? status : ra == BAUD ? {16'd0, baud_q} : ra == CTRL ? ctrl : 32'd0;
        unused_bits = ^{core_addr[1:0], core_wr_data[31:16], cnt9[8]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tmr_q <= '0;
            shift_q <= '0;
            idx_q <= '0;
            ovf_q <= 1'b0;
            baud_q <= DEFAULT_BAUD_DIV;
            en_q <= 1'b1;
            tx_q <= 1'b1;
            rd_q <= '0;
            hit_q <= 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
            odd_q <= 1'b0;
            par_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tmr_q <= tmr_d;
            shift_q <= shift_d;
            idx_q <= idx_d;
            ovf_q <= ovf_d;
            baud_q <= baud_d;
            en_q <= en_d;
            tx_q <= tx_d;
            rd_q <= rd_d;
            hit_q <= sel;
`ifdef MMIO_UART_TX_PARITY_EN
            odd_q <= odd_d;
            par_q <= par_d;
`endif
        end
    end

    assign core_rd_data = rd_q;
    assign hit = hit_q;
    assign uart_tx = tx_q;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed self-checking bench for mmio_uart_tx (default 8N1 or MMIO_UART_TX_PARITY_EN build).
module tb_mmio_uart_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] core_addr = '0;
    logic core_wr_ena = 1'b0;
    logic [31:0] core_wr_data = '0;
    logic [31:0] core_rd_data;
    logic hit;
    logic uart_tx;
    int checks = 0;
    int errors = 0;

    mmio_uart_tx #(
        .BASE_ADDR(32'h0000_4000),
        .FIFO_DEPTH(8),
        .DEFAULT_BAUD_DIV(16'd533)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .core_addr    (core_addr),
        .core_wr_ena  (core_wr_ena),
        .core_wr_data (core_wr_data),
        .core_rd_data (core_rd_data),
        .hit          (hit),
        .uart_tx      (uart_tx)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        core_addr = a;
        core_wr_data = d;
        core_wr_ena = 1'b1;
        @(negedge clk);
        core_wr_ena = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp, input logic exp_hit);
        core_addr = a;
        core_wr_ena = 1'b0;
        @(negedge clk);
        chk(tag, core_rd_data, exp);
        chk({tag, " hit"}, {31'd0, hit}, {31'd0, exp_hit});
    endtask

    // Caller sits on the negedge where the start bit should first be seen.
    task automatic frame(input string tag, input logic [7:0] b, input int div, input bit par_en, input bit par);
        logic [10:0] bits;
        logic obs;
        int nb;
        bits = {1'b1, par_en ? par : 1'b1, b, 1'b0};
        nb = par_en ? 11 : 10;
        for (int k = 0; k < nb; k++) begin
            obs = bits[k];
            for (int c = 0; c < div; c++) begin
                if (k > 0 || c > 0) @(negedge clk);
                if (uart_tx !== bits[k]) obs = uart_tx;
            end
            chk($sformatf("%s bit%0d", tag, k), {31'd0, obs}, {31'd0, bits[k]});
        end
    endtask

    task automatic hold_high(input string tag, input int n);
        logic obs;
        obs = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) obs = uart_tx;
        end
        chk(tag, {31'd0, obs}, 32'd1);
    endtask

    task automatic start_latency(input string tag);
        chk({tag, " tx+1"}, {31'd0, uart_tx}, 32'd1);
        @(negedge clk);
        chk({tag, " tx+2"}, {31'd0, uart_tx}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset tx", {31'd0, uart_tx}, 32'd1);
        chk("reset hit", {31'd0, hit}, 32'd0);
        chk("reset rd", core_rd_data, 32'd0);
        rd("reset status", 32'h0000_4004, 32'h0000_0002, 1'b1);
        rd("reset baud", 32'h0000_4008, 32'd533, 1'b1);
        rd("reset ctrl", 32'h0000_400C, 32'd1, 1'b1);
        rd("txdata read", 32'h0000_4000, 32'd0, 1'b1);
        rd("outside window", 32'h0000_3FFC, 32'd0, 1'b0);
        rd("above window", 32'h0000_4010, 32'd0, 1'b0);

        wr(32'h0000_4008, 32'd4);
        rd("baud 4", 32'h0000_400A, 32'd4, 1'b1);
        wr(32'h0000_4000, 32'h0000_0055);
        start_latency("f55");
        frame("f55", 8'h55, 4, 1'b0, 1'b0);
        @(negedge clk);
        chk("f55 idle after", {31'd0, uart_tx}, 32'd1);
        rd("f55 status idle", 32'h0000_4004, 32'h0000_0002, 1'b1);

        wr(32'h0000_4008, 32'd100);
        for (int i = 0; i < 9; i++) wr(32'h0000_4000, 32'hA0 + i);
        rd("nine status", 32'h0000_4004, 32'h0000_0805, 1'b1);
        wr(32'h0000_4000, 32'h0000_00AA);
        rd("overflow status", 32'h0000_4004, 32'h0000_080D, 1'b1);
        wr(32'h0000_4006, 32'h0000_0008);
        rd("overflow cleared", 32'h0000_4004, 32'h0000_0805, 1'b1);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst tx high", {31'd0, uart_tx}, 32'd1);
        rd("rst status", 32'h0000_4004, 32'h0000_0002, 1'b1);
        rd("rst baud", 32'h0000_4008, 32'd533, 1'b1);

        wr(32'h0000_4008, 32'd0);
        rd("baud clamp", 32'h0000_4008, 32'd2, 1'b1);
        wr(32'h0000_4000, 32'h0000_00FF);
        wr(32'h0000_4000, 32'h0000_0000);
        chk("fff tx+2", {31'd0, uart_tx}, 32'd1);
        @(negedge clk);
        frame("fFF", 8'hFF, 2, 1'b0, 1'b0);
        @(negedge clk);
        frame("f00 b2b", 8'h00, 2, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b idle after", {31'd0, uart_tx}, 32'd1);

        wr(32'h0000_400C, 32'd0);
        rd("ctrl off", 32'h0000_400C, 32'd0, 1'b1);
        wr(32'h0000_4000, 32'h0000_003C);
        hold_high("disabled hold", 8);
        rd("disabled status", 32'h0000_4004, 32'h0000_0100, 1'b1);
        wr(32'h0000_400C, 32'd1);
        start_latency("f3C");
        frame("f3C", 8'h3C, 2, 1'b0, 1'b0);

        wr(32'h0000_4008, 32'd4);
        wr(32'h0000_4000, 32'h0000_0000);
        wr(32'h0000_4000, 32'h0000_0033);
        @(negedge clk);
        chk("mid start", {31'd0, uart_tx}, 32'd0);
        repeat (17) @(negedge clk);
        chk("mid data3", {31'd0, uart_tx}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid rst tx", {31'd0, uart_tx}, 32'd1);
        rst = 1'b0;
        rd("mid rst status", 32'h0000_4004, 32'h0000_0002, 1'b1);
        hold_high("mid rst discarded", 20);

        wr(32'h0000_4008, 32'd4);
        wr(32'h0000_400C, 32'd3);
`ifdef MMIO_UART_TX_PARITY_EN
        rd("ctrl parity", 32'h0000_400C, 32'd3, 1'b1);
        wr(32'h0000_4000, 32'h0000_0007);
        start_latency("f07");
        frame("f07 odd", 8'h07, 4, 1'b1, 1'b0);
`else
        rd("ctrl no parity", 32'h0000_400C, 32'd1, 1'b1);
        wr(32'h0000_4000, 32'h0000_0007);
        start_latency("f07");
        frame("f07", 8'h07, 4, 1'b0, 1'b0);
`endif
        @(negedge clk);
        chk("f07 idle after", {31'd0, uart_tx}, 32'd1);
        rd("final status", 32'h0000_4004, 32'h0000_0002, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that responds to the multicycle core's data-memory bus, the responder end of the core's mem_addr / mem_wr_ena / mem_wr_data / mem_rd_data interface. It decodes a 16-byte window at BASE_ADDR, buffers written bytes in a small FIFO, and serializes them 8N1 on a single output pin. The MMU instantiates it beside the LED/display/GPIO peripherals and muxes its read data onto core_rd_data when `hit` is asserted.

## Interface
- BASE_ADDR, 32'h0000_4000: word-aligned base of the 16-byte register window.
- FIFO_DEPTH, 8: TX FIFO entries; must be a power of two, 2 to 256.
- DEFAULT_BAUD_DIV, 533: reset value of BAUD_DIV, in clocks per bit (61.44 MHz / 115200).
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- core_addr  input  32  bus byte address from the core.
- core_wr_ena  input  1  write strobe, qualified by the address hit.
- core_wr_data  input  32  write data.
- core_rd_data  output  32  registered read data for the previous cycle's address.
- hit  output  1  registered; high when the previous cycle's core_addr was inside the window.
- uart_tx  output  1  serial line, idle high.

## Operation
- Window decode: `sel = (core_addr[31:4] == BASE_ADDR[31:4])`. Register is chosen by core_addr[3:2]; core_addr[1:0] is ignored.
- 0x0 TXDATA
  - Write pushes wr_data[7:0] into the FIFO.
  - Read returns 0.
- 0x4 STATUS (read-only except bit 3)
  - bit0 full; bit1 empty; bit2 busy (FSM not in IDLE); bit3 overflow (sticky); bits[15:8] FIFO count; other bits 0.
  - Writing with wr_data[3]=1 clears overflow.
- 0x8 BAUD_DIV: bits[15:0], read/write. A written value below 2 is stored as 2. The new value applies from the next bit boundary.
- 0xC CTRL: bit0 enable, read/write, reset value 1. Clearing enable lets the current frame finish, then holds off further frames.
- Push when full with no pop on the same edge: the byte is dropped and overflow is set. Push and pop on the same edge when full: the push is accepted and count is unchanged.
- Transmit FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE → START when the FIFO is non-empty and enable=1. The FIFO pops on this edge and the byte is latched into the shift register.
  - START: uart_tx=0 for one bit period → DATA.
  - DATA: 8 bits, LSB first, one bit period each; a 3-bit index counts them. After bit 7 → STOP (or PARITY).
  - STOP: uart_tx=1 for one bit period → IDLE.
- Bit timer: a 16-bit down-counter loaded with BAUD_DIV-1 at each bit start; the bit ends at 0.

## Timing
- Reset values: uart_tx=1, core_rd_data=0, hit=0, FSM=IDLE, FIFO empty, overflow=0, BAUD_DIV=DEFAULT_BAUD_DIV, enable=1.
- Read latency is 1 cycle: core_rd_data and hit are valid the cycle after the address is presented, matching the MMU's block-RAM timing.
- Writes take effect on the edge where core_wr_ena and sel are both high.
- First start bit: a write to an empty FIFO with the FSM idle drives uart_tx low 2 cycles after the write edge (1 cycle push, 1 cycle IDLE→START).
- Frame length is exactly 10×BAUD_DIV cycles (11× with parity). Back-to-back frames have no idle gap.
- Reset mid-frame: uart_tx is 1 on the cycle after rst is sampled, and the FIFO contents are discarded.

## Configuration
- MMIO_UART_TX_PARITY_EN defined:
  - Adds CTRL bit1 `parity_odd` (reset 0).
  - Adds the PARITY state between DATA and STOP, one bit period long.
  - The parity bit is XOR of the data bits for even parity, inverted for odd.
- MMIO_UART_TX_PARITY_EN undefined: no PARITY state, CTRL bit1 reads 0 and ignores writes, frames are 8N1.

## Structure
- mmio_uart_pkg holds:
  - register offset localparams: TXDATA=2'd0, STATUS=2'd1, BAUD=2'd2, CTRL=2'd3;
  - STATUS bit positions;
  - the `uart_tx_state_t` enum.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) provides push, pop, full, empty, count, with read data valid combinationally from the head entry.

## Test plan
- After reset: read STATUS → 0x0000_0002 (empty only); read BAUD_DIV → 533; uart_tx=1.
- BAUD_DIV=4, write 0x55:
  - uart_tx low 2 cycles after the write edge;
  - then 1,0,1,0,1,0,1,0, each 4 cycles;
  - then stop high;
  - frame is 40 cycles total.
- Write 9 bytes back-to-back with FIFO_DEPTH=8 and BAUD_DIV=100:
  - the first pops immediately, so all 9 are accepted and overflow=0;
  - a 10th write sets STATUS bit3, and a read gives count=8;
  - writing STATUS=0x8 clears it.
- Write BAUD_DIV=0 → reads back 2; a frame of 0xFF lasts 20 cycles.
- Assert rst during DATA bit 3 of 0x00 → uart_tx=1 the next cycle; STATUS=0x2 after reset.
- With MMIO_UART_TX_PARITY_EN and CTRL=0x3, send 0x07 → parity bit 0 (odd parity, three ones); frame is 11×BAUD_DIV cycles.
